// File: rtl/traffic_light_ctrl_pkg.sv
// Shared colour codes for the traffic-light sequencer and the RGB LED decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package traffic_light_ctrl_pkg;

    // 2-bit colour-select codes understood by the RGB decoder
    localparam logic [1:0] COLOR_WHITE  = 2'b00;
    localparam logic [1:0] COLOR_RED    = 2'b01;
    localparam logic [1:0] COLOR_GREEN  = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

endpackage

// File: rtl/traffic_light_ctrl_sec_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and pulses tick_o on the last count.
// Latency: tick_o is combinational from the count register; first tick TICK_DIV cycles after clr_i drops.
// Backpressure: none; clr_i holds the count at zero and suppresses the tick.
module sec_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned     CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap on the last count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Timed RED->GREEN->YELLOW sequencer with seconds countdown and pedestrian GREEN truncation.
// Latency: all outputs registered; a tick or input change shows on the outputs one cycle later.
// Backpressure: none; ped_req_i is latched every cycle while running, en_i low forces IDLE.
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned RED_SEC    = 5,
    parameter int unsigned GREEN_SEC  = 5,
    parameter int unsigned YELLOW_SEC = 2,
    parameter int unsigned PED_SEC    = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       ped_req_i,
    output logic [1:0] light_o,
    output logic [3:0] remain_o,
    output logic       ped_pend_o
);

    // State codes double as the colour codes, so light_o is the state register itself
    typedef enum logic [1:0] {
        ST_IDLE   = COLOR_WHITE,
        ST_RED    = COLOR_RED,
        ST_GREEN  = COLOR_GREEN,
        ST_YELLOW = COLOR_YELLOW
    } state_e;

    localparam logic [3:0] RED_LD    = 4'(RED_SEC);
    localparam logic [3:0] GREEN_LD  = 4'(GREEN_SEC);
    localparam logic [3:0] YELLOW_LD = 4'(YELLOW_SEC);
    localparam logic [3:0] PED_LD    = 4'(PED_SEC);

    state_e     state_q, state_d;
    logic [3:0] remain_q, remain_d;
    logic       ped_q, ped_d;
    logic       tick;
    logic       tick_clr;

    // Prescaler is parked at zero in IDLE and whenever the sequencer is being stopped
    assign tick_clr = (state_q == ST_IDLE) || !en_i;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    // Next state, countdown and pedestrian latch; disable has top priority
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        ped_d    = ped_q;

        if (!en_i) begin
            state_d  = ST_IDLE;
            remain_d = '0;
            ped_d    = 1'b0;
        end else if (state_q == ST_IDLE) begin
            // Requests made while idle are deliberately dropped
            state_d  = ST_RED;
            remain_d = RED_LD;
            ped_d    = 1'b0;
        end else begin
            ped_d = ped_q || ped_req_i;

            if ((state_q == ST_GREEN) && ped_q && (remain_q > PED_LD)) begin
                // Truncation beats a same-cycle tick; a held request re-latches harmlessly
                remain_d = PED_LD;
                ped_d    = ped_req_i;
            end else begin
                if ((state_q == ST_GREEN) && ped_q) begin
                    // Already short enough: just retire the request
                    ped_d = ped_req_i;
                end
                if (tick) begin
                    if (remain_q > 4'd1) begin
                        remain_d = remain_q - 4'd1;
                    end else begin
                        unique case (state_q)
                            ST_RED: begin
                                state_d  = ST_GREEN;
                                remain_d = GREEN_LD;
                            end
                            ST_GREEN: begin
                                state_d  = ST_YELLOW;
                                remain_d = YELLOW_LD;
                            end
                            ST_YELLOW: begin
                                state_d  = ST_RED;
                                remain_d = RED_LD;
                            end
                            default: begin
                                state_d  = ST_IDLE;
                                remain_d = '0;
                            end
                        endcase
                    end
                end
            end
        end
    end

    // State, countdown and latch registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            ped_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            ped_q    <= ped_d;
        end
    end

    assign light_o    = state_q;
    assign remain_o   = remain_q;
    assign ped_pend_o = ped_q;

`ifndef SYNTHESIS
    // Parameter legality checks; remain is 4 bits so no duration may exceed 15
    always @(posedge clk_i) begin
        assert (TICK_DIV >= 2)
            else $error("traffic_light_ctrl: TICK_DIV must be >= 2");
        assert (RED_SEC >= 1 && RED_SEC <= 15)
            else $error("traffic_light_ctrl: RED_SEC out of range 1..15");
        assert (GREEN_SEC >= 1 && GREEN_SEC <= 15)
            else $error("traffic_light_ctrl: GREEN_SEC out of range 1..15");
        assert (YELLOW_SEC >= 1 && YELLOW_SEC <= 15)
            else $error("traffic_light_ctrl: YELLOW_SEC out of range 1..15");
        assert (PED_SEC >= 1 && PED_SEC <= GREEN_SEC)
            else $error("traffic_light_ctrl: PED_SEC out of range 1..GREEN_SEC");
    end
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with TICK_DIV=4, RED=3, GREEN=3, YELLOW=1, PED=1.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Tasks run back to back and each assumes the phase position the previous one left behind.
module tb_traffic_light_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ped_req;
    logic [1:0] light;
    logic [3:0] remain;
    logic       ped;

    int total = 0;
    int bad   = 0;

    // One full cycle of expected (light, remain) pairs, each held 4 cycles
    logic [1:0] seq_light  [0:7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [3:0] seq_remain [0:7] = '{4'd3,  4'd2,  4'd1,  4'd3,  4'd2,  4'd1,  4'd1,  4'd3};

    traffic_light_ctrl #(
        .TICK_DIV   (4),
        .RED_SEC    (3),
        .GREEN_SEC  (3),
        .YELLOW_SEC (1),
        .PED_SEC    (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .ped_req_i  (ped_req),
        .light_o    (light),
        .remain_o   (remain),
        .ped_pend_o (ped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ped_req = 1'b0;
        #1;
        total++;
        if (light !== 2'b00 || remain !== 4'd0 || ped !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: light=%b remain=%0d ped=%b want 00/0/0", light, remain, ped);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (light !== 2'b00 || remain !== 4'd0 || ped !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: light=%b remain=%0d ped=%b want 00/0/0", i, light, remain, ped);
            end
        end
    endtask

    // Ends on the first cycle of the second RED (prescaler at 0)
    task automatic test_full_cycle();
        en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (s == 7 && c > 0) break;
                @(negedge clk);
                total++;
                if (light !== seq_light[s] || remain !== seq_remain[s] || ped !== 1'b0) begin
                    bad++;
                    $display("FAIL cycle[%0d.%0d]: light=%b remain=%0d ped=%b want %b/%0d/0",
                             s, c, light, remain, ped, seq_light[s], seq_remain[s]);
                end
            end
        end
    endtask

    // Ends on the first cycle of RED
    task automatic test_ped_green();
        repeat (12) @(negedge clk);
        total++;
        if (light !== 2'b10 || remain !== 4'd3) begin
            bad++;
            $display("FAIL pg_enter: light=%b remain=%0d want 10/3", light, remain);
        end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        total++;
        if (ped !== 1'b1 || remain !== 4'd3 || light !== 2'b10) begin
            bad++;
            $display("FAIL pg_latch: ped=%b remain=%0d light=%b want 1/3/10", ped, remain, light);
        end
        @(negedge clk);
        total++;
        if (ped !== 1'b0 || remain !== 4'd1 || light !== 2'b10) begin
            bad++;
            $display("FAIL pg_trunc: ped=%b remain=%0d light=%b want 0/1/10", ped, remain, light);
        end
        @(negedge clk);
        total++;
        if (light !== 2'b10 || remain !== 4'd1) begin
            bad++;
            $display("FAIL pg_hold: light=%b remain=%0d want 10/1", light, remain);
        end
        @(negedge clk);
        total++;
        if (light !== 2'b11 || remain !== 4'd1) begin
            bad++;
            $display("FAIL pg_yellow: light=%b remain=%0d want 11/1", light, remain);
        end
        repeat (4) @(negedge clk);
        total++;
        if (light !== 2'b01 || remain !== 4'd3) begin
            bad++;
            $display("FAIL pg_red: light=%b remain=%0d want 01/3", light, remain);
        end
    endtask

    // Ends on the first cycle of YELLOW
    task automatic test_ped_red();
        ped_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ped_req = 1'b0;
            total++;
            if (ped !== 1'b1 || light !== 2'b01) begin
                bad++;
                $display("FAIL pr_pending[%0d]: ped=%b light=%b want 1/01", i, ped, light);
            end
        end
        @(negedge clk);
        total++;
        if (light !== 2'b10 || remain !== 4'd3 || ped !== 1'b1) begin
            bad++;
            $display("FAIL pr_green_entry: light=%b remain=%0d ped=%b want 10/3/1", light, remain, ped);
        end
        @(negedge clk);
        total++;
        if (light !== 2'b10 || remain !== 4'd1 || ped !== 1'b0) begin
            bad++;
            $display("FAIL pr_served: light=%b remain=%0d ped=%b want 10/1/0", light, remain, ped);
        end
        repeat (3) @(negedge clk);
        total++;
        if (light !== 2'b11 || remain !== 4'd1) begin
            bad++;
            $display("FAIL pr_yellow: light=%b remain=%0d want 11/1", light, remain);
        end
    endtask

    // Ends on RED cycle 4 after re-enable (remain just became 2)
    task automatic test_en_drop();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        total++;
        if (ped !== 1'b1 || light !== 2'b11) begin
            bad++;
            $display("FAIL ed_pend: ped=%b light=%b want 1/11", ped, light);
        end
        en = 1'b0;
        @(negedge clk);
        total++;
        if (light !== 2'b00 || remain !== 4'd0 || ped !== 1'b0) begin
            bad++;
            $display("FAIL ed_idle: light=%b remain=%0d ped=%b want 00/0/0", light, remain, ped);
        end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        total++;
        if (light !== 2'b00 || remain !== 4'd0 || ped !== 1'b0) begin
            bad++;
            $display("FAIL ed_idle_req: light=%b remain=%0d ped=%b want 00/0/0", light, remain, ped);
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (light !== 2'b01 || remain !== 4'd3) begin
                bad++;
                $display("FAIL ed_red[%0d]: light=%b remain=%0d want 01/3", k, light, remain);
            end
        end
        @(negedge clk);
        total++;
        if (light !== 2'b01 || remain !== 4'd2) begin
            bad++;
            $display("FAIL ed_first_dec: light=%b remain=%0d want 01/2", light, remain);
        end
    endtask

    task automatic test_async_reset();
        repeat (9) @(negedge clk);
        total++;
        if (light !== 2'b10 || remain !== 4'd3) begin
            bad++;
            $display("FAIL ar_green: light=%b remain=%0d want 10/3", light, remain);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (light !== 2'b00 || remain !== 4'd0 || ped !== 1'b0) begin
            bad++;
            $display("FAIL ar_immediate: light=%b remain=%0d ped=%b want 00/0/0", light, remain, ped);
        end
        @(negedge clk);
        total++;
        if (light !== 2'b00 || remain !== 4'd0) begin
            bad++;
            $display("FAIL ar_held: light=%b remain=%0d want 00/0", light, remain);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (light !== 2'b01 || remain !== 4'd3) begin
            bad++;
            $display("FAIL ar_restart: light=%b remain=%0d want 01/3", light, remain);
        end
        repeat (3) @(negedge clk);
        total++;
        if (light !== 2'b01 || remain !== 4'd3) begin
            bad++;
            $display("FAIL ar_before_tick: light=%b remain=%0d want 01/3", light, remain);
        end
        @(negedge clk);
        total++;
        if (light !== 2'b01 || remain !== 4'd2) begin
            bad++;
            $display("FAIL ar_first_dec: light=%b remain=%0d want 01/2", light, remain);
        end
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_ped_green();
        test_ped_red();
        test_en_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Timed traffic-light sequencer that generates the 2-bit colour-select code consumed by the board RGB LED decoder. It cycles RED -> GREEN -> YELLOW -> RED with per-phase durations counted in seconds, and exposes the seconds remaining for a countdown display. A latched pedestrian request shortens the current GREEN phase. It sits between the board clock/buttons and the RGB decoder, replacing the manual switch inputs.

Parameters:
TICK_DIV, 100_000_000, clk_i cycles per one-second tick (>=2)
RED_SEC, 5, RED phase duration in seconds (1..15)
GREEN_SEC, 5, GREEN phase duration in seconds (1..15)
YELLOW_SEC, 2, YELLOW phase duration in seconds (1..15)
PED_SEC, 2, GREEN seconds left after a pedestrian truncation (1..GREEN_SEC)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
en_i  input  1  run enable; low forces IDLE (white)
ped_req_i  input  1  pedestrian request, level or pulse, sampled every cycle
light_o  output  2  colour code: 00 WHITE/idle, 01 RED, 10 GREEN, 11 YELLOW
remain_o  output  4  seconds remaining in current phase, 0 in IDLE
ped_pend_o  output  1  pedestrian request latched, not yet served

Behaviour:
- All outputs registered. Reset values: state IDLE, light_o=2'b00, remain_o=0, ped_pend_o=0, prescaler=0.
- States: IDLE, RED, GREEN, YELLOW. light_o always equals the code of the current state.
- IDLE: en_i=1 -> next cycle RED, remain=RED_SEC, prescaler cleared to 0.
- Any state with en_i=0 -> next cycle IDLE, remain=0, prescaler=0, ped_pend cleared. This takes priority over all other events.
- Prescaler counts 0..TICK_DIV-1 while not IDLE. tick is a one-cycle pulse when count==TICK_DIV-1, and count wraps to 0 on that cycle. First tick comes TICK_DIV cycles after phase entry from IDLE. The prescaler is not reset on phase changes, so phases stay aligned to seconds.
- On tick with remain>1: remain decrements.
- On tick with remain==1: advance RED->GREEN, GREEN->YELLOW, YELLOW->RED. Load remain with the new phase's *_SEC. light_o changes in the same registered update, one cycle after the tick.
- Each phase therefore lasts exactly *_SEC*TICK_DIV cycles in steady state.
- Pedestrian latch: ped_req_i=1 sets ped_pend on the next edge in RED, GREEN or YELLOW. Requests are ignored in IDLE.
- In GREEN with ped_pend=1:
  - if remain>PED_SEC, load remain=PED_SEC and clear ped_pend;
  - if remain<=PED_SEC, clear ped_pend with no change to remain.
- Truncation takes priority over a same-cycle tick decrement. The prescaler still wraps normally.
- A request held high keeps re-setting ped_pend. This is harmless because remain is already <=PED_SEC.
- A request during RED or YELLOW stays pending and is served on the first GREEN cycle.
- No counter overflow is possible: remain is never loaded above 15.
- Out-of-range parameters are illegal. The block must carry simulation-only assertions for this.
- Reset asserted mid-phase returns everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package (also imported by the RGB decoder): 2-bit colour constants COLOR_WHITE=2'b00, COLOR_RED=2'b01, COLOR_GREEN=2'b10, COLOR_YELLOW=2'b11.
- State encoding typedef for IDLE/RED/GREEN/YELLOW is local to this block.
- One sub-module, sec_tick_gen:
  - inputs: clk_i, rst_i, clr_i;
  - parameter: TICK_DIV;
  - output: tick_o;
  - function: prescaler plus tick pulse.

Test Plan (TICK_DIV=4, RED_SEC=3, GREEN_SEC=3, YELLOW_SEC=1, PED_SEC=1):
1. Reset, en_i=0 for 10 cycles -> light_o=00, remain_o=0, ped_pend_o=0 throughout.
2. Raise en_i -> next cycle light_o=01, remain_o=3.
   - remain_o goes 3,2,1, each value held 4 cycles.
   - Then GREEN (10) for 12 cycles, YELLOW (11) for 4 cycles, back to RED with remain_o=3.
3. Pulse ped_req_i in GREEN while remain_o=3 -> ped_pend_o=1 for one cycle, then remain_o=1 and ped_pend_o=0. YELLOW follows at the next tick.
4. Pulse ped_req_i in RED -> ped_pend_o stays 1 through RED. On the first GREEN cycle remain_o=3; one cycle later remain_o=1 and ped_pend_o=0.
5. Drop en_i mid-YELLOW -> next cycle light_o=00, remain_o=0, ped_pend_o=0. Re-raise en_i -> RED with remain_o=3, and the first decrement comes exactly 4 cycles later.
6. Assert rst_i asynchronously mid-GREEN (between edges) -> light_o=00 and remain_o=0 without waiting for a clock edge. The sequence restarts cleanly after rst_i falls with en_i=1.
